// File: rtl/req_state_seq_if.sv
// +--------------------------------------------------------------------------+
// | req_state_seq_if : handshake bundle between requester and sequencer      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface req_state_seq_if;
    logic       start_i;
    logic       ack_i;
    logic       abort_i;
    logic [1:0] state_o;
    logic       req_o;
    logic       timeout_o;
    logic [7:0] done_cnt_o;

    modport master (
        output start_i, ack_i, abort_i,
        input  state_o, req_o, timeout_o, done_cnt_o
    );

    modport slave (
        input  start_i, ack_i, abort_i,
        output state_o, req_o, timeout_o, done_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/req_state_seq.sv
// +--------------------------------------------------------------------------+
// | req_state_seq : four-phase request/ack sequencer with timeout and abort  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module req_state_seq #(
    parameter int TIMEOUT = 8
) (
    input  wire              clk_i,
    input  wire              rst_i,
    req_state_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout;
    logic [7:0]       done_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            timeout  <= 1'b0;
            done_cnt <= 8'd0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        state    <= REQ;
                        wait_cnt <= '0;
                    end
                end
                REQ: begin
                    // abort beats ack, ack beats the timeout on the same edge
                    if (bus.abort_i) begin
                        state <= IDLE;
                    end else if (bus.ack_i) begin
                        state <= ACK;
                    end else if (wait_cnt == LAST_CNT) begin
                        state   <= IDLE;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ACK: begin
                    if (bus.abort_i) begin
                        state <= IDLE;
                    end else if (!bus.ack_i) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (done_cnt != 8'hFF) begin
                        done_cnt <= done_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign bus.state_o    = state;
    assign bus.req_o      = (state == REQ);
    assign bus.timeout_o  = timeout;
    assign bus.done_cnt_o = done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_req_state_seq.sv
// +--------------------------------------------------------------------------+
// | tb_req_state_seq : directed-vector bench for req_state_seq (TIMEOUT=8)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_req_state_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    req_state_seq_if bus ();

    req_state_seq #(.TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic ab);
        bus.start_i = s;
        bus.ack_i   = a;
        bus.abort_i = ab;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle, then compare every output against hand-computed values.
    task automatic apply(input string tag, input logic s, input logic a, input logic ab,
                         input int e_state, input int e_req, input int e_to, input int e_cnt);
        drive(s, a, ab);
        check({tag, ".state"}, int'(bus.state_o), e_state);
        check({tag, ".req"}, int'(bus.req_o), e_req);
        check({tag, ".timeout"}, int'(bus.timeout_o), e_to);
        check({tag, ".done_cnt"}, int'(bus.done_cnt_o), e_cnt);
    endtask

    task automatic transaction();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.ack_i   = 1'b0;
        bus.abort_i = 1'b0;

        // Reset held with start asserted
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        apply("reset", 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        apply("idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        // Normal handshake: 1,1,2,2,3,0 ; start during DONE is ignored
        apply("hs1", 1'b1, 1'b0, 1'b0, 1, 1, 0, 0);
        apply("hs2", 1'b0, 1'b0, 1'b0, 1, 1, 0, 0);
        apply("hs3", 1'b0, 1'b1, 1'b0, 2, 0, 0, 0);
        apply("hs4", 1'b0, 1'b1, 1'b0, 2, 0, 0, 0);
        apply("hs5", 1'b0, 1'b0, 1'b0, 3, 0, 0, 0);
        apply("hs6", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1);
        apply("hs7", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);

        // Timeout: REQ for exactly 8 cycles, then a single timeout pulse
        apply("to_start", 1'b1, 1'b0, 1'b0, 1, 1, 0, 1);
        for (int i = 0; i < 7; i++) begin
            apply($sformatf("to_req%0d", i + 2), 1'b0, 1'b0, 1'b0, 1, 1, 0, 1);
        end
        apply("to_fire", 1'b0, 1'b0, 1'b0, 0, 0, 1, 1);
        apply("to_after", 1'b0, 1'b0, 1'b0, 0, 0, 0, 1);

        // Ack on the 8th REQ cycle wins over the timeout
        apply("bnd_start", 1'b1, 1'b0, 1'b0, 1, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0);
        end
        apply("bnd_req8", 1'b0, 1'b0, 1'b0, 1, 1, 0, 1);
        apply("bnd_ack", 1'b0, 1'b1, 1'b0, 2, 0, 0, 1);
        apply("bnd_done", 1'b0, 1'b0, 1'b0, 3, 0, 0, 1);
        apply("bnd_idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 2);

        // Aborts
        apply("abr_start", 1'b1, 1'b0, 1'b0, 1, 1, 0, 2);
        apply("abr_req", 1'b0, 1'b0, 1'b1, 0, 0, 0, 2);
        apply("abr_start2", 1'b1, 1'b0, 1'b0, 1, 1, 0, 2);
        apply("abr_toack", 1'b0, 1'b1, 1'b0, 2, 0, 0, 2);
        apply("abr_ack", 1'b0, 1'b1, 1'b1, 0, 0, 0, 2);
        apply("abr_ackrel", 1'b0, 1'b0, 1'b0, 0, 0, 0, 2);
        apply("abr_start3", 1'b1, 1'b0, 1'b0, 1, 1, 0, 2);
        apply("abr_reqack", 1'b0, 1'b1, 1'b1, 0, 0, 0, 2);
        apply("abr_idle", 1'b1, 1'b0, 1'b1, 0, 0, 0, 2);

        // Saturation: 2 + 253 = 255, then one more stays at 255
        for (int i = 0; i < 253; i++) begin
            transaction();
        end
        check("sat_reach", int'(bus.done_cnt_o), 255);
        transaction();
        check("sat_hold", int'(bus.done_cnt_o), 255);
        check("sat_state", int'(bus.state_o), 0);

        // Reset while in REQ
        apply("mid_req", 1'b1, 1'b0, 1'b0, 1, 1, 0, 255);
        rst = 1'b1;
        apply("mid_rst", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        rst = 1'b0;
        apply("mid_after", 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/req_state_seq.md
# req_state_seq

Request/acknowledge sequencer that drives the 2-bit state code consumed by the downstream `unique case` state decoder. It runs a four-state, four-phase handshake (request, acknowledge, release, complete) with a bounded request timeout and an abort path. It also keeps a saturating count of completed transactions. Every one of the four 2-bit codes is a legal state, so the downstream decoder needs no default arm.

## Interface
- `TIMEOUT`, default 8: maximum number of cycles spent in REQ before giving up. Legal range is 2..255.
- `CNT_W` is a localparam equal to `$clog2(TIMEOUT)`. It sets the width of the internal wait counter.
- Clock and reset: one clock, `clk_i`. Reset is `rst_i`: synchronous, active-high.
- `clk_i`  in  1  clock; all state updates on its rising edge
- `rst_i`  in  1  synchronous active-high reset
- `start_i`  in  1  start a transaction; sampled only in IDLE
- `ack_i`  in  1  acknowledge from the responder (level)
- `abort_i`  in  1  abandon the current transaction; returns to IDLE
- `state_o`  out  2  current state code: 0=IDLE, 1=REQ, 2=ACK, 3=DONE
- `req_o`  out  1  request to the responder; high exactly while the state is REQ
- `timeout_o`  out  1  one-cycle pulse on REQ timeout
- `done_cnt_o`  out  8  completed-transaction count, saturating at 255

## Operation
- Reset values: `state_o`=0, `req_o`=0, `timeout_o`=0, `done_cnt_o`=0. The wait counter also resets to 0.
- **IDLE (0)**
  - `start_i`=1 and `abort_i`=0: go to REQ and clear the wait counter.
  - Otherwise stay in IDLE.
- **REQ (1):** `req_o`=1. Priority is abort > ack > timeout.
  - `abort_i`: go to IDLE.
  - Else `ack_i`: go to ACK.
  - Else, wait counter == TIMEOUT-1: go to IDLE and set `timeout_o`=1 for the next cycle.
  - Else: increment the wait counter.
- **ACK (2):** `req_o`=0; wait for the responder to release.
  - `abort_i`: go to IDLE.
  - Else `ack_i`=0: go to DONE.
  - Else stay in ACK. There is no timeout in ACK.
- **DONE (3):** lasts one cycle.
  - `done_cnt_o` increments by 1, saturating at 255 (255 stays 255).
  - Always go to IDLE; `start_i` and `abort_i` are ignored.
  - A new transaction therefore needs at least one IDLE cycle.
- Inputs outside their sampled state are ignored: `start_i` outside IDLE, `ack_i` in IDLE/DONE.
- Reset asserted mid-transaction: the next edge forces all reset values, including `req_o` low and `timeout_o` low. `done_cnt_o` clears.
- State transitions use `unique case` over all four codes with no default arm.

## Timing
- All outputs are registered or decoded only from registered state. There is no combinational path from any input to any output.
- `start_i` high at edge N (state IDLE): `state_o`=1 and `req_o`=1 after edge N.
- Minimum transaction (ack on the first REQ cycle, released on the first ACK cycle) visits states 1, 2, 3, 0.
- Timeout:
  - With no ack, REQ lasts exactly TIMEOUT cycles.
  - On the edge that leaves REQ, `state_o` becomes 0 and `timeout_o` is high for exactly that one following cycle.
- `done_cnt_o` updates on the edge that leaves DONE. It is visible while `state_o`=0.
- `ack_i` arriving in the same cycle as the timeout condition: ack wins, go to ACK, no `timeout_o`.
- `abort_i` arriving in the same cycle as `ack_i` or the timeout condition: abort wins, no `timeout_o`.

## Test plan
- Reset then idle:
  - Hold `rst_i`=1 for 2 cycles with `start_i`=1 → all outputs 0.
  - After release with `start_i`=0 → `state_o` stays 0.
- Normal handshake:
  - `start_i` pulse; `ack_i`=1 two cycles later; `ack_i`=0 after two more → `state_o` sequence 0,1,1,2,2,3,0.
  - `req_o` high for exactly 2 cycles; `done_cnt_o` ends at 1.
- Timeout, TIMEOUT=8: start with no ack → REQ for 8 cycles, then `state_o`=0 with `timeout_o`=1 for 1 cycle; `done_cnt_o` unchanged.
- Ack on the boundary: ack on the 8th REQ cycle → ACK entered, `timeout_o` stays 0.
- Abort:
  - `abort_i` in REQ → IDLE next cycle.
  - `abort_i` in ACK → IDLE next cycle, `done_cnt_o` unchanged.
  - `abort_i` together with `start_i` in IDLE → stays IDLE.
- Saturation and mid-reset:
  - 256 back-to-back transactions → `done_cnt_o`=255 and stays 255.
  - Then `rst_i` asserted while in REQ → `req_o`=0, `done_cnt_o`=0 after one edge.
